// File: rtl/decode_pkg.sv
// Shared types and constants for the RV32I decode stage: control bundle,
// opcode classes, immediate formats and writeback-select encodings.
package decode_pkg;

  typedef struct packed {
    logic       regWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       ALUSrc;
    logic       BranchSig;
    logic       Jump;
    logic       JAL;
    logic       JALR;
    logic       Branch;
    logic       Load;
    logic [1:0] ALUOp;
    logic [2:0] ImmSrc;
  } ctrl_t;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} stage_state_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALUIMM = 7'b0010011;
  localparam logic [6:0] OP_ALUREG = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] Imm_I = 3'd0;
  localparam logic [2:0] Imm_S = 3'd1;
  localparam logic [2:0] Imm_B = 3'd2;
  localparam logic [2:0] Imm_U = 3'd3;
  localparam logic [2:0] Imm_J = 3'd4;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  // Reassembles the scattered immediate bits into a sign-extended 32-bit value.
  function automatic logic [31:0] imm_gen(input logic [31:0] instr, input logic [2:0] sel);
    logic [31:0] imm;
    case (sel)
      Imm_I:   imm = {{20{instr[31]}}, instr[31:20]};
      Imm_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      Imm_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      Imm_U:   imm = {instr[31:12], 12'b0};
      Imm_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = 32'b0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decode_stage_hazard.sv
// Load-use hazard detection between the incoming instruction's sources and
// the load currently held in the stage's output register.
module id_hazard (
  input  logic       isLui_i,
  input  logic       isAuipc_i,
  input  logic       isJal_i,
  input  logic       isAluReg_i,
  input  logic       isBranch_i,
  input  logic       isStore_i,
  input  logic       illegal_i,
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  input  logic       heldValid_i,
  input  logic       heldLoad_i,
  input  logic [4:0] heldRd_i,
  output logic       hazard_o
);

  logic usesRs1;
  logic usesRs2;
  logic rdMatch;

  assign usesRs1 = !(isLui_i || isAuipc_i || isJal_i);
  assign usesRs2 = isAluReg_i || isBranch_i || isStore_i;

  // x0 never carries a real value, so a load into it cannot create a dependency.
  assign rdMatch = (usesRs1 && (rs1_i == heldRd_i)) || (usesRs2 && (rs2_i == heldRd_i));
  assign hazard_o = heldValid_i && heldLoad_i && (heldRd_i != 5'd0) && rdMatch && !illegal_i;

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage with valid/ready handshake, load-use bubble,
// flush and saturating stall counter. Illegal-opcode check: DECODE_ILLEGAL_EN.
module decode_stage
  import decode_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [PC_WIDTH-1:0]   in_pc,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic [4:0]            out_rd,
  output logic [4:0]            out_rs1,
  output logic [4:0]            out_rs2,
  output logic [DATA_WIDTH-1:0] out_imm,
  output ctrl_t                 out_ctrl,
  output logic [1:0]            out_wb_sel,
  output logic                  out_illegal,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);

  logic [6:0] opcode;
  logic isLui, isAuipc, isJal, isJalr, isBranch, isLoad, isStore, isAluImm, isAluReg;
  logic illegal_d;
  ctrl_t ctrl_d;
  logic [1:0] wbSel_d;
  logic [DATA_WIDTH-1:0] imm_d;
  logic hazard;
  logic accept;

  stage_state_e state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q;
  logic [4:0] rd_q, rs1_q, rs2_q;
  logic [DATA_WIDTH-1:0] imm_q;
  ctrl_t ctrl_q;
  logic [1:0] wbSel_q;
  logic illegal_q;
  logic [CNT_WIDTH-1:0] stallCnt_q;

  assign opcode   = in_instr[6:0];
  assign isLui    = (opcode == OP_LUI);
  assign isAuipc  = (opcode == OP_AUIPC);
  assign isJal    = (opcode == OP_JAL);
  assign isJalr   = (opcode == OP_JALR);
  assign isBranch = (opcode == OP_BRANCH);
  assign isLoad   = (opcode == OP_LOAD);
  assign isStore  = (opcode == OP_STORE);
  assign isAluImm = (opcode == OP_ALUIMM);
  assign isAluReg = (opcode == OP_ALUREG);

`ifdef DECODE_ILLEGAL_EN
  logic isSystem;
  assign isSystem  = (opcode == OP_SYSTEM);
  assign illegal_d = !(isLui || isAuipc || isJal || isJalr || isBranch || isLoad ||
                       isStore || isAluImm || isAluReg || isSystem) ||
                     (in_instr[1:0] != 2'b11);
`else
  assign illegal_d = 1'b0;
`endif

  always_comb begin
    ctrl_d           = '0;
    ctrl_d.regWrite  = isLui || isAuipc || isJal || isJalr || isLoad || isAluImm || isAluReg;
    ctrl_d.MemRead   = isLoad;
    ctrl_d.MemWrite  = isStore;
    ctrl_d.ALUSrc    = isLoad || isStore || isAluImm || isJalr || isLui || isAuipc;
    ctrl_d.BranchSig = isBranch;
    ctrl_d.Jump      = isJal || isJalr;
    ctrl_d.JAL       = isJal;
    ctrl_d.JALR      = isJalr;
    ctrl_d.Branch    = isBranch;
    ctrl_d.Load      = isLoad;
    ctrl_d.ALUOp     = isBranch ? 2'b01 : isAluReg ? 2'b10 : isAluImm ? 2'b11 : 2'b00;
    if (isStore)              ctrl_d.ImmSrc = Imm_S;
    else if (isBranch)        ctrl_d.ImmSrc = Imm_B;
    else if (isLui || isAuipc) ctrl_d.ImmSrc = Imm_U;
    else if (isJal)           ctrl_d.ImmSrc = Imm_J;
    else                      ctrl_d.ImmSrc = Imm_I;
    // Strobes with side effects are squashed so a bad opcode cannot corrupt state.
    if (illegal_d) begin
      ctrl_d.regWrite  = 1'b0;
      ctrl_d.MemRead   = 1'b0;
      ctrl_d.MemWrite  = 1'b0;
      ctrl_d.BranchSig = 1'b0;
      ctrl_d.Jump      = 1'b0;
    end
  end

  assign wbSel_d = (isJal || isJalr) ? WB_PC4 : isLoad ? WB_MEM : WB_ALU;
  assign imm_d   = DATA_WIDTH'($signed(imm_gen(in_instr, ctrl_d.ImmSrc)));

  id_hazard u_hazard (
    .isLui_i     (isLui),
    .isAuipc_i   (isAuipc),
    .isJal_i     (isJal),
    .isAluReg_i  (isAluReg),
    .isBranch_i  (isBranch),
    .isStore_i   (isStore),
    .illegal_i   (illegal_d),
    .rs1_i       (in_instr[19:15]),
    .rs2_i       (in_instr[24:20]),
    .heldValid_i (out_valid),
    .heldLoad_i  (ctrl_q.Load),
    .heldRd_i    (rd_q),
    .hazard_o    (hazard)
  );

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (flush || (out_ready && !accept)) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state_q == FULL);
    in_ready  = rst_n && !flush && !hazard && (!out_valid || out_ready);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q      <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      imm_q     <= '0;
      ctrl_q    <= '0;
      wbSel_q   <= '0;
      illegal_q <= 1'b0;
    end else if (accept) begin
      pc_q      <= in_pc;
      rd_q      <= in_instr[11:7];
      rs1_q     <= in_instr[19:15];
      rs2_q     <= in_instr[24:20];
      imm_q     <= imm_d;
      ctrl_q    <= ctrl_d;
      wbSel_q   <= wbSel_d;
      illegal_q <= illegal_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      stallCnt_q <= '0;
    else if (in_valid && hazard && !flush && !(&stallCnt_q))
      stallCnt_q <= stallCnt_q + CNT_WIDTH'(1);
  end

  assign out_pc      = pc_q;
  assign out_rd      = rd_q;
  assign out_rs1     = rs1_q;
  assign out_rs2     = rs2_q;
  assign out_imm     = imm_q;
  assign out_ctrl    = ctrl_q;
  assign out_wb_sel  = wbSel_q;
  assign out_illegal = illegal_q;
  assign stall_cnt   = stallCnt_q;

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered instruction-decode pipeline stage with a valid/ready handshake on both sides. It takes fetched instruction/PC pairs and decodes them into register indices, the immediate, control strobes and writeback select. The results are held in an output pipeline register. The stage detects load-use hazards against the instruction it holds and inserts a bubble when one occurs. It also supports a synchronous flush and keeps a saturating stall counter. It sits between fetch and execute, and it replaces purely combinational decode in pipelined cores.

## Interface
- DATA_WIDTH, 32: width of `out_imm`.
- PC_WIDTH, 32: width of PC in/out.
- CNT_WIDTH, 16: width of the stall counter.

- clk  in  1: sole clock, rising edge.
- rst_n  in  1: synchronous, active-low reset.
- in_valid  in  1: fetch offers `in_instr`/`in_pc`.
- in_ready  out  1: stage accepts this cycle.
- in_instr  in  32: RV32I instruction.
- in_pc  in  PC_WIDTH: instruction address.
- flush  in  1: discard held instruction, block acceptance this cycle.
- out_valid  out  1: output register holds a decoded instruction.
- out_ready  in  1: execute consumes this cycle.
- out_pc  out  PC_WIDTH: registered PC.
- out_rd, out_rs1, out_rs2  out  5 each: registered indices.
- out_imm  out  DATA_WIDTH: registered sign-extended immediate.
- out_ctrl  out  ctrl_t: regWrite, MemRead, MemWrite, ALUSrc, BranchSig, Jump, JAL, JALR, Branch, Load, ALUOp[1:0], ImmSrc[2:0].
- out_wb_sel  out  2: 0 = ALU, 1 = MEM, 2 = PC+4.
- out_illegal  out  1: illegal-instruction flag (see Configuration).
- stall_cnt  out  CNT_WIDTH: count of hazard-stall cycles.

## Operation
- Combinational decode of `in_instr` covers the slicer, coarse opcode decode, main control, the immediate generator and the wb_sel rule. The wb_sel rule is JAL|JALR → 2, MemtoReg → 1, else 0.
- Register-use flags:
  - uses_rs1 = !(LUI|AUIPC|JAL).
  - uses_rs2 = ALUreg|Branch|Store.
- hazard = out_valid & out_ctrl.Load & (out_rd≠0) & ((uses_rs1 & rs1==out_rd) | (uses_rs2 & rs2==out_rd)).
- in_ready = rst_n & !flush & !hazard & (!out_valid | out_ready).
- Accept when in_valid & in_ready. On accept, all out_* fields load from decode and out_valid←1.
- When out_valid & out_ready and there is no accept, out_valid←0. This applies whenever no new instruction is accepted, including on hazard, which produces the bubble.
- Fields hold their value while out_valid=1 & !out_ready. They are don't-care when out_valid=0, but the implementation must not toggle them then.
- flush priority: out_valid←0 and no accept, regardless of other inputs.
- stall_cnt increments each cycle with in_valid & hazard & !flush. It saturates at all-ones. It clears only on reset.
- State summary:
  - EMPTY (out_valid=0) goes to FULL on accept.
  - FULL goes to EMPTY on consume without accept, or on flush.
  - FULL stays FULL on consume with accept, or when stalled by !out_ready.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 instruction/cycle when out_ready=1 and there is no hazard.
- A load-use pair always costs exactly one bubble cycle.
- in_ready is combinational from out_ready, flush, in_instr and the registered state. There are no combinational paths from in_valid to in_ready.
- Reset values: out_valid=0, stall_cnt=0, all out_* fields=0 (out_wb_sel=0, out_illegal=0). in_ready=0 while rst_n=0.
- Reset mid-transfer: the held instruction is dropped and nothing is accepted that cycle.

## Configuration
- `DECODE_ILLEGAL_EN` defined:
  - An instruction is flagged when its opcode is not one of the ten RV32I classes, or when instr[1:0]≠2'b11.
  - On a flagged instruction, out_illegal=1, and out_ctrl.regWrite, MemRead, MemWrite, BranchSig and Jump are forced 0.
  - A flagged instruction never raises the hazard.
- Undefined: out_illegal is tied 0 and no check logic is generated.

## Structure
- Shared package `decode_pkg` holds:
  - `ctrl_t` packed struct.
  - Opcode constants.
  - `Imm_I/S/B/U/J` encodings.
  - wb_sel encodings WB_ALU/WB_MEM/WB_PC4.
- Sub-module `id_hazard` computes uses_rs1/uses_rs2 and hazard from the decoded sources and the held rd/Load.

## Test plan
- Reset, then send 0x00228333 (add x6,x5,x2) with out_ready=1.
  - Next cycle: out_valid=1, rd=6, rs1=5, rs2=2, regWrite=1, wb_sel=0.
- Send 0x0000A283 (lw x5,0(x1)) followed by 0x00228333.
  - in_ready=0 for one cycle and out_valid=0 for one cycle (bubble); then the add appears; stall_cnt=1.
- Send 0x0000A003 (lw x0) followed by 0x00200333 (add x6,x0,x2).
  - No stall; back-to-back out_valid; stall_cnt=0.
- Hold out_ready=0 for 3 cycles while an instruction is valid.
  - out_* stable, in_ready=0; on release, the next instruction follows with no loss or duplication.
- Assert flush while out_valid=1 and in_valid=1.
  - Next cycle out_valid=0; the offered instruction is not accepted.
- With `DECODE_ILLEGAL_EN`, send 0x00000000.
  - out_illegal=1, regWrite=0, MemWrite=0.
  - Without the macro: out_illegal=0.
